// File: rtl/plate_pkg.sv
// rtl/plate_pkg.sv - move codes, FSM states and direction types for plate_control
package plate_pkg;

   localparam logic [3:0] CODE_HOLD = 4'b1111;
   localparam logic [3:0] CODE_R1   = 4'b0001;
   localparam logic [3:0] CODE_L1   = 4'b0100;
   localparam logic [3:0] CODE_R2   = 4'b0011;
   localparam logic [3:0] CODE_L2   = 4'b0110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_SLOW = 2'd2,
      ST_FAST = 2'd3
   } state_e;

   typedef enum logic {
      DIR_R = 1'b0,
      DIR_L = 1'b1
   } dir_e;

   function automatic logic [3:0] move_code(input dir_e dir, input logic fast);
      if (dir == DIR_L) return fast ? CODE_L2 : CODE_L1;
      return fast ? CODE_R2 : CODE_R1;
   endfunction

endpackage

// File: rtl/plate_control_if.sv
// rtl/plate_control_if.sv - button/tick inputs and move-code outputs of plate_control
interface plate_control_if;
   logic       btn_left;
   logic       btn_right;
   logic       tick;
   logic       enable;
   logic [3:0] control;
   logic       step;
   logic [1:0] state_dbg;

   modport master (
      output btn_left, btn_right, tick, enable,
      input  control, step, state_dbg
   );

   modport slave (
      input  btn_left, btn_right, tick, enable,
      output control, step, state_dbg
   );
endinterface

// File: rtl/plate_control_debounce.sv
// rtl/plate_control_debounce.sv - two-flop synchronizer plus stable-count debouncer
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync_q, sync_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d  = {sync_q[0], raw};
      level_d = level_q;
      cnt_d   = '0;
      // Counter only ever reaches DEBOUNCE_CYCLES-1 before flipping, so it cannot wrap.
      if (sync_q[1] != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
endmodule

// File: rtl/plate_control.sv
// rtl/plate_control.sv - debounced press/auto-repeat FSM producing plate move codes
module plate_control
   import plate_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 4,
   parameter int FAST_AFTER      = 6
) (
   input  logic clock,
   input  logic reset,
   plate_control_if.slave bus
);
   localparam int DW = $clog2(REPEAT_DELAY + 1);
   localparam int RW = $clog2(FAST_AFTER + 1);

   logic deb_l, deb_r;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
      .clock(clock), .reset(reset), .raw(bus.btn_left), .level(deb_l)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
      .clock(clock), .reset(reset), .raw(bus.btn_right), .level(deb_r)
   );

   state_e        state_q, state_d;
   dir_e          dir_q, dir_d;
   logic          pending_q, pending_d;
   logic [DW-1:0] delay_q, delay_d;
   logic [RW-1:0] rep_q, rep_d;
   logic [3:0]    control_q, control_d;
   logic          step_q, step_d;

   logic          abort, issue, fast, dir_held;
   logic [DW-1:0] delay_inc;

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      pending_d = pending_q;
      delay_d   = delay_q;
      rep_d     = rep_q;
      control_d = CODE_HOLD;
      step_d    = 1'b0;
      issue     = 1'b0;
      fast      = 1'b0;
      dir_held  = (dir_q == DIR_L) ? deb_l : deb_r;
      abort     = !bus.enable || (deb_l && deb_r) || !dir_held;
      delay_inc = (delay_q == DW'(REPEAT_DELAY)) ? delay_q : delay_q + DW'(1);

      case (state_q)
         ST_IDLE: begin
            if (bus.enable && (deb_l ^ deb_r)) begin
               state_d   = ST_WAIT;
               dir_d     = deb_l ? DIR_L : DIR_R;
               pending_d = 1'b1;
               delay_d   = '0;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (bus.tick) begin
               if (pending_q) begin
                  issue     = 1'b1;
                  pending_d = 1'b0;
               end else begin
                  delay_d = delay_inc;
                  if (delay_inc == DW'(REPEAT_DELAY)) begin
                     state_d = ST_SLOW;
                     rep_d   = '0;
                     issue   = 1'b1;
                  end
               end
            end
         end
         ST_SLOW: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (bus.tick) begin
               issue = 1'b1;
               if (rep_q == RW'(FAST_AFTER)) state_d = ST_FAST;
               else                          rep_d   = rep_q + RW'(1);
            end
         end
         ST_FAST: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (bus.tick) begin
               issue = 1'b1;
               fast  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (issue) begin
         control_d = move_code(dir_q, fast);
         step_d    = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         dir_q     <= DIR_R;
         pending_q <= 1'b0;
         delay_q   <= '0;
         rep_q     <= '0;
         control_q <= CODE_HOLD;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
         delay_q   <= delay_d;
         rep_q     <= rep_d;
         control_q <= control_d;
         step_q    <= step_d;
      end
   end

   assign bus.control   = control_q;
   assign bus.step      = step_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_plate_control.sv
// tb/tb_plate_control.sv - scenario bench for plate_control against a tick-index model
module tb_plate_control;
   localparam int DB = 4;
   localparam int RD = 2;
   localparam int FA = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   plate_control_if bus();

   plate_control #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .FAST_AFTER(FA)
   ) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );

   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_tick();
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
   endtask

   // Expected code for the k-th tick of a hold: first step, silent gap, single steps, then doubles.
   function automatic logic [3:0] model_code(input int k, input bit left);
      if (k == 1 || (k > RD && k <= RD + FA + 2)) return left ? 4'b0100 : 4'b0001;
      if (k <= RD) return 4'b1111;
      return left ? 4'b0110 : 4'b0011;
   endfunction

   task automatic test_reset();
      cyc(2);
      total++;
      if ({bus.step, bus.control, bus.state_dbg} !== 7'b0_1111_00) begin
         bad++;
         $display("FAIL reset step/control/state got=%b want=0_1111_00", {bus.step, bus.control, bus.state_dbg});
      end
      reset = 1'b0;
      cyc(2);
   endtask

   task automatic test_glitch();
      bus.btn_right = 1'b1;
      cyc(3);
      bus.btn_right = 1'b0;
      for (int i = 0; i < 24; i++) begin
         bus.tick = (i % 3 == 0);
         cyc(1);
         total++;
         if ({bus.step, bus.control, bus.state_dbg} !== 7'b0_1111_00) begin
            bad++;
            $display("FAIL glitch cycle %0d got=%b want=0_1111_00", i, {bus.step, bus.control, bus.state_dbg});
         end
      end
      bus.tick = 1'b0;
   endtask

   task automatic test_debounce_timing();
      bus.btn_right = 1'b1;
      cyc(6);
      total++;
      if (bus.state_dbg !== 2'd0) begin
         bad++;
         $display("FAIL deb_edge6 state got=%0d want=0", bus.state_dbg);
      end
      cyc(1);
      total++;
      if (bus.state_dbg !== 2'd1) begin
         bad++;
         $display("FAIL deb_edge7 state got=%0d want=1", bus.state_dbg);
      end
      bus.btn_right = 1'b0;
      cyc(8);
      total++;
      if (bus.state_dbg !== 2'd0) begin
         bad++;
         $display("FAIL deb_release state got=%0d want=0", bus.state_dbg);
      end
   endtask

   task automatic test_single_tap();
      bus.btn_right = 1'b1;
      cyc(8);
      pulse_tick();
      total++;
      if ({bus.step, bus.control} !== 5'b1_0001) begin
         bad++;
         $display("FAIL tap_step got=%b want=1_0001", {bus.step, bus.control});
      end
      bus.btn_right = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bus.tick = (i == 9);
         cyc(1);
         total++;
         if ({bus.step, bus.control} !== 5'b0_1111) begin
            bad++;
            $display("FAIL tap_after cycle %0d got=%b want=0_1111", i, {bus.step, bus.control});
         end
      end
      bus.tick = 1'b0;
   endtask

   task automatic test_long_hold_and_release_tick();
      int n;
      int gap;
      logic [3:0] exp;
      bus.btn_left = 1'b1;
      cyc(8);
      n = $urandom_range(11, 8);
      for (int k = 1; k <= n; k++) begin
         gap = $urandom_range(12, 3);
         for (int g = 0; g < gap; g++) begin
            cyc(1);
            total++;
            if ({bus.step, bus.control} !== 5'b0_1111) begin
               bad++;
               $display("FAIL hold_gap k=%0d g=%0d got=%b want=0_1111", k, g, {bus.step, bus.control});
            end
         end
         pulse_tick();
         exp = model_code(k, 1'b1);
         total++;
         if ({bus.step, bus.control} !== {exp != 4'b1111, exp}) begin
            bad++;
            $display("FAIL hold_tick k=%0d got=%b want=%b", k, {bus.step, bus.control}, {exp != 4'b1111, exp});
         end
      end
      total++;
      if (bus.state_dbg !== 2'd3) begin
         bad++;
         $display("FAIL hold_fast state got=%0d want=3", bus.state_dbg);
      end
      bus.btn_left = 1'b0;
      cyc(6);
      pulse_tick();
      total++;
      if ({bus.step, bus.control, bus.state_dbg} !== 7'b0_1111_00) begin
         bad++;
         $display("FAIL release_tick got=%b want=0_1111_00", {bus.step, bus.control, bus.state_dbg});
      end
      cyc(4);
   endtask

   task automatic test_both_buttons();
      logic [3:0] exp;
      bus.btn_right = 1'b1;
      cyc(8);
      for (int k = 1; k <= 3; k++) begin
         cyc(4);
         pulse_tick();
         exp = model_code(k, 1'b0);
         total++;
         if ({bus.step, bus.control} !== {exp != 4'b1111, exp}) begin
            bad++;
            $display("FAIL both_r k=%0d got=%b want=%b", k, {bus.step, bus.control}, {exp != 4'b1111, exp});
         end
      end
      total++;
      if (bus.state_dbg !== 2'd2) begin
         bad++;
         $display("FAIL both_slow state got=%0d want=2", bus.state_dbg);
      end
      bus.btn_left = 1'b1;
      cyc(6);
      pulse_tick();
      total++;
      if ({bus.step, bus.control, bus.state_dbg} !== 7'b0_1111_00) begin
         bad++;
         $display("FAIL both_abort got=%b want=0_1111_00", {bus.step, bus.control, bus.state_dbg});
      end
      bus.btn_right = 1'b0;
      cyc(7);
      total++;
      if (bus.state_dbg !== 2'd1) begin
         bad++;
         $display("FAIL both_left_wait state got=%0d want=1", bus.state_dbg);
      end
      pulse_tick();
      total++;
      if ({bus.step, bus.control} !== 5'b1_0100) begin
         bad++;
         $display("FAIL both_left_step got=%b want=1_0100", {bus.step, bus.control});
      end
      bus.btn_left = 1'b0;
      cyc(10);
   endtask

   task automatic test_enable_drop();
      bus.btn_left = 1'b1;
      cyc(8);
      for (int k = 1; k <= 7; k++) begin
         cyc($urandom_range(5, 2));
         pulse_tick();
      end
      total++;
      if ({bus.step, bus.control, bus.state_dbg} !== 7'b1_0110_11) begin
         bad++;
         $display("FAIL en_fast got=%b want=1_0110_11", {bus.step, bus.control, bus.state_dbg});
      end
      bus.enable = 1'b0;
      cyc(2);
      pulse_tick();
      total++;
      if ({bus.step, bus.control, bus.state_dbg} !== 7'b0_1111_00) begin
         bad++;
         $display("FAIL en_abort got=%b want=0_1111_00", {bus.step, bus.control, bus.state_dbg});
      end
      cyc(2);
      pulse_tick();
      total++;
      if ({bus.step, bus.control, bus.state_dbg} !== 7'b0_1111_00) begin
         bad++;
         $display("FAIL en_low_tick got=%b want=0_1111_00", {bus.step, bus.control, bus.state_dbg});
      end
      bus.enable = 1'b1;
      cyc(1);
      total++;
      if (bus.state_dbg !== 2'd1) begin
         bad++;
         $display("FAIL en_repress state got=%0d want=1", bus.state_dbg);
      end
      pulse_tick();
      total++;
      if ({bus.step, bus.control} !== 5'b1_0100) begin
         bad++;
         $display("FAIL en_repress_step got=%b want=1_0100", {bus.step, bus.control});
      end
      bus.btn_left = 1'b0;
      cyc(10);
   endtask

   task automatic test_async_reset();
      bus.btn_right = 1'b1;
      cyc(8);
      for (int k = 1; k <= 7; k++) begin
         cyc(3);
         pulse_tick();
      end
      total++;
      if ({bus.step, bus.control} !== 5'b1_0011) begin
         bad++;
         $display("FAIL rst_pre_fast got=%b want=1_0011", {bus.step, bus.control});
      end
      #3;
      reset = 1'b1;
      #1;
      total++;
      if ({bus.step, bus.control, bus.state_dbg} !== 7'b0_1111_00) begin
         bad++;
         $display("FAIL rst_async got=%b want=0_1111_00", {bus.step, bus.control, bus.state_dbg});
      end
      @(posedge clock);
      #3;
      reset = 1'b0;
      cyc(6);
      total++;
      if (bus.state_dbg !== 2'd0) begin
         bad++;
         $display("FAIL rst_redeb_early state got=%0d want=0", bus.state_dbg);
      end
      cyc(1);
      total++;
      if (bus.state_dbg !== 2'd1) begin
         bad++;
         $display("FAIL rst_redeb state got=%0d want=1", bus.state_dbg);
      end
      pulse_tick();
      total++;
      if ({bus.step, bus.control} !== 5'b1_0001) begin
         bad++;
         $display("FAIL rst_new_press got=%b want=1_0001", {bus.step, bus.control});
      end
      bus.btn_right = 1'b0;
      cyc(10);
   endtask

   initial begin
      bus.btn_left  = 1'b0;
      bus.btn_right = 1'b0;
      bus.tick      = 1'b0;
      bus.enable    = 1'b1;
      test_reset();
      test_glitch();
      test_debounce_timing();
      test_single_tap();
      test_long_hold_and_release_tick();
      test_both_buttons();
      test_enable_drop();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/plate_control.md
Name: plate_control

Overview:
- Upstream stage of the plate register: converts raw left/right push-buttons into the 4-bit move code the plate consumes.
- Synchronizes and debounces both buttons, then runs a press/auto-repeat FSM gated by the game tick.
- Emits a one-step move on press, repeats after a delay, and accelerates to two-step moves on long holds.
- Plate and this block share one clock; the plate sees a move code for exactly one cycle per issued step and the hold code (4'b1111) otherwise.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clocks required before the debounced level changes; must be >= 1.
- REPEAT_DELAY, 4: ticks between the first step and the first auto-repeat step; must be >= 1.
- FAST_AFTER, 6: number of single-step repeats before switching to two-step codes; must be >= 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_left  input  1  raw left button, active-high, asynchronous to clock.
- btn_right  input  1  raw right button, active-high, asynchronous to clock.
- tick  input  1  game-frame strobe, one clock wide, synchronous.
- enable  input  1  game active; low forces idle.
- control  output  4  move code to plate, registered.
- step  output  1  high in the same cycle control carries a move code.
- state_dbg  output  2  current FSM state encoding.

Behaviour:
- Codes: HOLD=4'b1111, R1=4'b0001, L1=4'b0100, R2=4'b0011, L2=4'b0110.
- Reset (async, while high): control=HOLD, step=0, state=IDLE, sync flops=0, debounced levels=0, all counters=0.
- Synchronizer: 2 flops per button.
- Debounce: per button, a counter increments while the synced level differs from the debounced level and clears when they agree. When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A clean raw edge is visible on the debounced level DEBOUNCE_CYCLES+2 clocks later.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM states: IDLE=0, WAIT=1, SLOW=2, FAST=3. Latched direction dir (L/R). Counters delay_cnt and rep_cnt.
- Global abort, any state:
  - enable=0, both debounced high, or the dir button released -> next state IDLE, no step issued on that tick.
  - Abort has priority over a same-cycle tick.
- IDLE:
  - Exactly one debounced button high and enable=1 -> latch dir, pending=1, delay_cnt=0, go WAIT.
  - No step is issued at entry.
- WAIT, on each tick:
  - If pending, issue a 1-step in dir and clear pending.
  - Otherwise increment delay_cnt.
  - When delay_cnt reaches REPEAT_DELAY, go SLOW with rep_cnt=0 and issue a 1-step on that same tick.
- SLOW, on each tick: issue a 1-step and increment rep_cnt. When rep_cnt reaches FAST_AFTER, go FAST; that tick's step is still 1-step.
- FAST, on each tick: issue a 2-step (R2/L2).
- Output timing: a step decided on tick in cycle N appears as control=code, step=1 in cycle N+1 only. In all other cycles control=HOLD, step=0.
- Direction swap: holding L then pressing R -> both high -> IDLE. When L is released, R alone is a new press from IDLE.
- Ticks arriving while in IDLE are ignored.
- Counters saturate; no wrap-around.
- Reset asserted mid-hold returns to IDLE. After reset is released, a still-held button is treated as a new press once it has debounced again from 0.

Decomposition:
- Package plate_pkg: code constants (HOLD, R1, L1, R2, L2), the FSM state enum, and a direction enum.
- Sub-module btn_debounce: 2-flop synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES. Instantiated twice.

Test Plan:
- Params used throughout: DEBOUNCE_CYCLES=4, REPEAT_DELAY=2, FAST_AFTER=2.
- Debounce: a 3-cycle pulse on btn_right -> no step ever. A clean right press -> debounced high exactly 6 clocks after the raw edge.
- Single tap: right press, held through one tick, released before the next -> exactly one cycle of control=0001, step=1; HOLD everywhere else.
- Long hold left, ticks every 10 clocks -> step sequence L1, (gap), L1, L1, L1, L1, then L2 on every tick. Verify the step cycle is always tick+1.
- Both buttons: hold right into SLOW, press left -> next control is HOLD, state_dbg=0. Release right -> left press starts WAIT; the next tick gives 0100.
- Release and tick in the same cycle -> no step. Deassert enable mid-FAST -> IDLE and HOLD.
- Assert reset asynchronously mid-FAST (between clock edges) -> control=1111, step=0, state_dbg=0 immediately.
